// File: rtl/ico_uart_pkg.sv
// ico_uart_pkg: shared state encoding, frame constants and helpers for the UART transmitter.
package ico_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ico_uart_if.sv
// ico_uart_if: core-side write strobe and status bundle of the UART transmitter.
interface ico_uart_if
    import ico_uart_pkg::*;
#(
    parameter int AW = 3
);
    logic [UART_DATA_BITS-1:0] wr_data;
    logic                      wr_stb;
    logic                      clr_ovr;
    logic                      full;
    logic                      empty;
    logic                      busy;
    logic                      overrun;
    logic [AW:0]               level;

    modport master (output wr_data, wr_stb, clr_ovr, input full, empty, busy, overrun, level);
    modport slave  (input wr_data, wr_stb, clr_ovr, output full, empty, busy, overrun, level);
endinterface

// File: rtl/ico_sync_fifo.sv
// ico_sync_fifo: single-clock FIFO with combinational head and registered occupancy flags.
module ico_sync_fifo
    import ico_uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_BITS,
    parameter int AW    = 3
) (
    input  logic             clk_core,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [2**AW];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    // full/empty come from the registered level, so a write while full is refused even if a pop lands
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
        level_d = level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_core) begin
        if (do_push) mem[wptr_q] <= din;
    end

    assign dout  = mem[rptr_q];
    assign full  = level_q == {1'b1, {AW{1'b0}}};
    assign empty = level_q == '0;
    assign level = level_q;
endmodule

// File: rtl/ico_uart_tx.sv
// ico_uart_tx: buffered 8N1 transmitter, LSB first at a fixed clk_core divisor,
// with FIFO status and a sticky overrun flag for polling firmware.
module ico_uart_tx
    import ico_uart_pkg::*;
#(
    parameter int DIVISOR = 22,
    parameter int FIFO_AW = 3
) (
    input  logic     clk_core,
    input  logic     reset_n,
    ico_uart_if.slave bus,
    output logic     tx
);
    localparam int            DW       = clog2(DIVISOR);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIVISOR - 1);
    localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);

    if (DIVISOR < 2 || DIVISOR > 65535) begin : g_div_range
        $error("ico_uart_tx: DIVISOR %0d outside 2..65535", DIVISOR);
    end

    uart_state_e                state_q, state_d;
    logic [DW-1:0]              div_q, div_d;
    logic [2:0]                 bit_q, bit_d;
    logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
    logic                       tx_q, tx_d;
    logic                       ovr_q, ovr_d;
    logic                       last, pop, fifo_full, fifo_empty;
    logic [UART_DATA_BITS-1:0]  head;
    logic [FIFO_AW:0]           fifo_level;

    ico_sync_fifo #(.WIDTH(UART_DATA_BITS), .AW(FIFO_AW)) u_fifo (
        .clk_core (clk_core),
        .reset_n  (reset_n),
        .push     (bus.wr_stb),
        .pop      (pop),
        .din      (bus.wr_data),
        .dout     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    always_comb begin
        last    = div_q == DIV_LAST;
        state_d = state_q;
        div_d   = last ? '0 : div_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        // a drop in the same cycle as a clear leaves the flag set
        ovr_d   = (bus.wr_stb && fifo_full) || (ovr_q && !bus.clr_ovr);
        case (state_q)
            ST_IDLE: begin
                div_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: if (last) begin
                state_d = ST_DATA;
                bit_d   = '0;
                tx_d    = shift_q[0];
            end
            ST_DATA: if (last) begin
                if (bit_q == BIT_LAST) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end else begin
                    bit_d   = bit_q + 1'b1;
                    shift_d = shift_q >> 1;
                    tx_d    = shift_q[1];
                end
            end
            ST_STOP: if (last) begin
                // chain straight into the next start bit when more data is waiting
                pop     = !fifo_empty;
                shift_d = fifo_empty ? shift_q : head;
                state_d = fifo_empty ? ST_IDLE : ST_START;
                tx_d    = fifo_empty;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovr_q   <= ovr_d;
        end
    end

    assign tx          = tx_q;
    assign bus.busy    = state_q != ST_IDLE;
    assign bus.full    = fifo_full;
    assign bus.empty   = fifo_empty;
    assign bus.overrun = ovr_q;
    assign bus.level   = fifo_level;
endmodule

// File: tb/tb_ico_uart_tx.sv
// tb_ico_uart_tx: drives a DIVISOR=4 and a DIVISOR=22 instance; a line decoder per instance
// pops expected bytes from a scoreboard queue while the main thread checks cycle timing and status.
module tb_ico_uart_tx;
    logic clk_core = 1'b0;
    logic rst_a_n = 1'b0, rst_b_n = 1'b0;
    logic tx_a, tx_b;
    logic rst_seen_a = 1'b0, rst_seen_b = 1'b0;
    logic [7:0] sb_a [$];
    logic [7:0] sb_b [$];
    int errors = 0, checks = 0;

    always #5 clk_core = ~clk_core;

    ico_uart_if #(.AW(3)) bus_a ();
    ico_uart_if #(.AW(3)) bus_b ();

    ico_uart_tx #(.DIVISOR(4), .FIFO_AW(3)) dut_a (
        .clk_core (clk_core), .reset_n (rst_a_n), .bus (bus_a), .tx (tx_a));
    ico_uart_tx #(.DIVISOR(22), .FIFO_AW(3)) dut_b (
        .clk_core (clk_core), .reset_n (rst_b_n), .bus (bus_b), .tx (tx_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_core);
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int j, input int d);
        return (j < d) ? 1'b0 : (j < 9 * d) ? b[(j - d) / d] : 1'b1;
    endfunction

    // decode frames off the line and compare against the scoreboard
    task automatic mon(input bit w, input int d);
        logic [7:0] sh;
        logic [7:0] e;
        logic st, sp;
        forever begin
            if (w) @(negedge tx_b); else @(negedge tx_a);
            if (w) rst_seen_b = 1'b0; else rst_seen_a = 1'b0;
            repeat (d / 2) @(negedge clk_core);
            st = w ? tx_b : tx_a;
            for (int i = 0; i < 8; i++) begin
                repeat (d) @(negedge clk_core);
                sh[i] = w ? tx_b : tx_a;
            end
            repeat (d) @(negedge clk_core);
            sp = w ? tx_b : tx_a;
            if (!(w ? rst_seen_b : rst_seen_a)) begin
                check(w ? "b_start" : "a_start", st, 0);
                check(w ? "b_stop" : "a_stop", sp, 1);
                check(w ? "b_sb_avail" : "a_sb_avail", (w ? sb_b.size() : sb_a.size()) != 0, 1);
                if ((w ? sb_b.size() : sb_a.size()) != 0) begin
                    e = w ? sb_b.pop_front() : sb_a.pop_front();
                    check(w ? "b_byte" : "a_byte", sh, e);
                end
            end
        end
    endtask

    always @(negedge rst_a_n) rst_seen_a = 1'b1;
    always @(negedge rst_b_n) rst_seen_b = 1'b1;
    initial mon(1'b0, 4);
    initial mon(1'b1, 22);

    // n frames on dut_a: b[0] at E0, b[1] at E0+1, b[2] landing on the last STOP cycle of frame 0
    task automatic stream_a(input string tag, input logic [7:0] b [3], input int n);
        bus_a.wr_data = b[0];
        bus_a.wr_stb  = 1'b1;
        sb_a.push_back(b[0]);
        tick(1);
        check({tag, "_lvl_e0"}, bus_a.level, 1);
        check({tag, "_tx_e0"}, tx_a, 1);
        check({tag, "_busy_e0"}, bus_a.busy, 0);
        if (n > 1) begin
            bus_a.wr_data = b[1];
            sb_a.push_back(b[1]);
        end else bus_a.wr_stb = 1'b0;
        tick(1);
        bus_a.wr_stb = 1'b0;
        for (int k = 0; k <= 40 * n; k++) begin
            check({tag, "_tx"}, tx_a, (k < 40 * n) ? exp_bit(b[(k / 40) % 3], k % 40, 4) : 1'b1);
            check({tag, "_busy"}, bus_a.busy, k < 40 * n);
            if (k < 2) begin
                check({tag, "_lvl"}, bus_a.level, n > 1);
                check({tag, "_empty"}, bus_a.empty, n == 1);
            end
            if (n == 3 && k == 39) begin
                check({tag, "_lvl_stop"}, bus_a.level, 1);
                bus_a.wr_data = b[2];
                bus_a.wr_stb  = 1'b1;
                sb_a.push_back(b[2]);
            end
            if (n == 3 && k == 40) begin
                check({tag, "_lvl_chain"}, bus_a.level, 1);
                bus_a.wr_stb = 1'b0;
            end
            tick(1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, lows;
        bus_a.wr_stb = 1'b0; bus_a.wr_data = '0; bus_a.clr_ovr = 1'b0;
        bus_b.wr_stb = 1'b0; bus_b.wr_data = '0; bus_b.clr_ovr = 1'b0;
        tick(3);
        check("rst_tx", tx_a, 1);
        check("rst_busy", bus_a.busy, 0);
        check("rst_full", bus_a.full, 0);
        check("rst_empty", bus_a.empty, 1);
        check("rst_ovr", bus_a.overrun, 0);
        check("rst_level", bus_a.level, 0);
        check("rst_tx_b", tx_b, 1);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        tick(2);

        stream_a("t1", '{8'h55, 8'h00, 8'h00}, 1);
        tick(5);
        stream_a("t2", '{8'h00, 8'hFF, 8'h00}, 2);
        tick(5);
        stream_a("t5", '{8'h3C, 8'hC3, 8'h96}, 3);

        // fill dut_b past capacity: the first byte pops, the next eight fill the FIFO
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                check("b_level_peak", bus_b.level, 8);
                check("b_full", bus_b.full, 1);
                check("b_ovr_before", bus_b.overrun, 0);
            end
            bus_b.wr_data = 8'(8'h30 + i);
            bus_b.wr_stb  = 1'b1;
            if (i < 9) sb_b.push_back(8'(8'h30 + i));
            tick(1);
        end
        bus_b.wr_stb = 1'b0;
        check("b_ovr_set", bus_b.overrun, 1);
        check("b_level_drop", bus_b.level, 8);
        bus_b.clr_ovr = 1'b1;
        tick(1);
        bus_b.clr_ovr = 1'b0;
        check("b_ovr_clr", bus_b.overrun, 0);
        bus_b.wr_data = 8'hEE;
        bus_b.wr_stb  = 1'b1;
        bus_b.clr_ovr = 1'b1;
        tick(1);
        bus_b.wr_stb  = 1'b0;
        bus_b.clr_ovr = 1'b0;
        check("b_ovr_set_wins", bus_b.overrun, 1);
        check("b_level_still", bus_b.level, 8);
        bus_b.clr_ovr = 1'b1;
        tick(1);
        bus_b.clr_ovr = 1'b0;
        check("b_ovr_clr2", bus_b.overrun, 0);
        t = 0;
        while ((bus_b.busy || !bus_b.empty) && t < 3000) begin
            tick(1);
            t++;
        end
        check("b_drain_in_time", t < 3000, 1);
        tick(3);

        // reset during bit3 of 0xA5 with three bytes queued
        bus_b.wr_data = 8'hA5; bus_b.wr_stb = 1'b1; sb_b.push_back(8'hA5);
        tick(1);
        bus_b.wr_data = 8'h11; sb_b.push_back(8'h11);
        tick(1);
        bus_b.wr_data = 8'h22; sb_b.push_back(8'h22);
        tick(1);
        bus_b.wr_data = 8'h33; sb_b.push_back(8'h33);
        tick(1);
        bus_b.wr_stb = 1'b0;
        check("b_rst_queued", bus_b.level, 3);
        tick(92);
        check("b_bit3_tx", tx_b, 0);
        check("b_bit3_busy", bus_b.busy, 1);
        rst_b_n = 1'b0;
        #1;
        check("b_rst_tx", tx_b, 1);
        check("b_rst_level", bus_b.level, 0);
        check("b_rst_busy", bus_b.busy, 0);
        check("b_rst_empty", bus_b.empty, 1);
        sb_b.delete();
        tick(2);
        rst_b_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            tick(1);
            if (tx_b !== 1'b1) lows++;
        end
        check("b_no_frames_after_rst", lows, 0);
        check("b_idle_after_rst", bus_b.busy, 0);

        check("a_sb_left", sb_a.size(), 0);
        check("b_sb_left", sb_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
